// File: rtl/btb_predictor.sv
// Branch target buffer: tagged entries, saturating direction counters and
// optional gshare indexing. Combinational lookup, single-port training.
module btb_predictor #(
  parameter int N        = 32,
  parameter int DEPTH    = 256,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 0,
  localparam int GW      = (GHR_BITS > 0) ? GHR_BITS : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_ready,
  input  logic          i_lookup_valid,
  input  logic [N-1:0]  i_lookup_pc,
  output logic          o_pred_hit,
  output logic          o_pred_taken,
  output logic [N-1:0]  o_pred_target,
  output logic [GW-1:0] o_pred_ghr,
  input  logic          i_upd_valid,
  input  logic [N-1:0]  i_upd_pc,
  input  logic [N-1:0]  i_upd_target,
  input  logic          i_upd_taken,
  input  logic [GW-1:0] i_upd_ghr
);

  localparam int IW = $clog2(DEPTH);
  localparam int TW = N - IW - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK =
    CTR_BITS'(1 << (CTR_BITS - 1));

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       sweep_q, sweep_d;
  logic                ready_q, ready_d;
  logic [GW-1:0]       ghr_q, ghr_d;
  logic [DEPTH-1:0]    valid_q, valid_d;

  logic [TW-1:0]       tag_q [DEPTH];
  logic [N-1:0]        tgt_q [DEPTH];
  logic [CTR_BITS-1:0] ctr_q [DEPTH];

  function automatic logic [IW-1:0] ghr_ext(
    input logic [GW-1:0] g
  );
    return (GHR_BITS > 0) ? IW'(g) : '0;
  endfunction

  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic [IW-1:0] up_idx;
  logic [TW-1:0] up_tag;
  logic          up_acc;
  logic          up_hit;
  logic          alloc;
  logic          train;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_wd;
  logic [GW:0]   ghr_sh;

  assign lk_idx = i_lookup_pc[IW+1:2] ^ ghr_ext(ghr_q);
  assign lk_tag = i_lookup_pc[N-1:IW+2];
  assign up_idx = i_upd_pc[IW+1:2] ^ ghr_ext(i_upd_ghr);
  assign up_tag = i_upd_pc[N-1:IW+2];
  assign ghr_sh = {ghr_q, i_upd_taken};

  assign o_ready      = ready_q;
  assign o_pred_ghr   = ghr_q;
  assign o_pred_hit   = ready_q & i_lookup_valid & valid_q[lk_idx]
                      & (tag_q[lk_idx] == lk_tag);
  assign o_pred_taken = o_pred_hit & ctr_q[lk_idx][CTR_BITS-1];
  assign o_pred_target = o_pred_taken ? tgt_q[lk_idx]
                                      : i_lookup_pc + N'(4);

  always_comb begin
    up_acc  = i_upd_valid & ready_q;
    up_hit  = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
    train   = up_acc & up_hit;
    alloc   = up_acc & ~up_hit & i_upd_taken;
    ctr_cur = ctr_q[up_idx];
    ctr_wd  = ctr_cur;
    if (alloc) begin
      ctr_wd = CTR_WEAK;
    end else if (i_upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_wd = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_wd = ctr_cur - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready_d = ready_q;
    ghr_d   = ghr_q;
    valid_d = valid_q;
    unique case (state_q)
      S_INIT: begin
        valid_d[sweep_q] = 1'b0;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == IW'(DEPTH - 1)) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end
      end
      S_READY: begin
        if (alloc) valid_d[up_idx] = 1'b1;
        if (up_acc) ghr_d = (GHR_BITS > 0) ? ghr_sh[GW-1:0] : '0;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= ready_d;
      ghr_q   <= ghr_d;
    end
  end

  // Valid bits have no reset of their own; the INIT sweep clears them.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (alloc) tag_q[up_idx] <= up_tag;
    if (up_acc & i_upd_taken) tgt_q[up_idx] <= i_upd_target;
    if (alloc | train) ctr_q[up_idx] <= ctr_wd;
  end

  logic unused_ok;
  assign unused_ok = ^{i_lookup_pc[1:0], i_upd_pc[1:0],
                       ghr_sh[GW], i_upd_ghr};

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: gshare config checked against a table model
// of entries indexed by arithmetic on the PC and history.
module tb_btb_predictor;

  localparam int DEP = 256;
  localparam int GHB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_ready;
  logic        i_lookup_valid = 1'b0;
  logic [31:0] i_lookup_pc = '0;
  logic        o_pred_hit;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic [3:0]  o_pred_ghr;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_pc = '0;
  logic [31:0] i_upd_target = '0;
  logic        i_upd_taken = 1'b0;
  logic [3:0]  i_upd_ghr = '0;

  btb_predictor #(
    .N(32), .DEPTH(DEP), .CTR_BITS(2), .GHR_BITS(GHB)
  ) dut (
    .clk(clk), .rst(rst), .o_ready(o_ready),
    .i_lookup_valid(i_lookup_valid), .i_lookup_pc(i_lookup_pc),
    .o_pred_hit(o_pred_hit), .o_pred_taken(o_pred_taken),
    .o_pred_target(o_pred_target), .o_pred_ghr(o_pred_ghr),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc),
    .i_upd_target(i_upd_target), .i_upd_taken(i_upd_taken),
    .i_upd_ghr(i_upd_ghr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit          m_valid [DEP];
  int unsigned m_tag   [DEP];
  int unsigned m_tgt   [DEP];
  int          m_ctr   [DEP];
  int          m_ghr = 0;
  int          m_cnt = 0;

  logic        s_ready, s_hit, s_taken;
  logic [31:0] s_tgt;
  logic [3:0]  s_ghr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pcf(input int e, input int t,
                                      input int g);
    return (32'(t) << 10) | (32'((e ^ g) % DEP) << 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) m_valid[i] = 1'b0;
    m_ghr = 0;
    m_cnt = 0;
  endtask

  // One cycle: drive, compare the combinational outputs, then clock.
  task automatic step(input logic r, input logic lv,
                      input logic [31:0] lpc, input logic uv,
                      input logic [31:0] upc, input logic [31:0] utg,
                      input logic ut, input logic [3:0] ug);
    int idx;
    bit e_rdy, e_hit, e_tk;
    int unsigned e_tgt, tg;
    rst = r; i_lookup_valid = lv; i_lookup_pc = lpc;
    i_upd_valid = uv; i_upd_pc = upc; i_upd_target = utg;
    i_upd_taken = ut; i_upd_ghr = ug;
    #2;
    e_rdy = (m_cnt >= DEP);
    idx = ((lpc >> 2) % DEP) ^ m_ghr;
    e_hit = e_rdy && lv && m_valid[idx] && (m_tag[idx] == (lpc >> 10));
    e_tk = e_hit && (m_ctr[idx] >= 2);
    e_tgt = e_tk ? m_tgt[idx] : lpc + 4;
    s_ready = o_ready; s_hit = o_pred_hit; s_taken = o_pred_taken;
    s_tgt = o_pred_target; s_ghr = o_pred_ghr;
    chk("ready", 32'(s_ready), 32'(e_rdy));
    chk("hit", 32'(s_hit), 32'(e_hit));
    chk("taken", 32'(s_taken), 32'(e_tk));
    chk("target", s_tgt, e_tgt);
    chk("ghr", 32'(s_ghr), 32'(m_ghr));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (e_rdy && uv) begin
        idx = ((upc >> 2) % DEP) ^ int'(ug);
        tg = upc >> 10;
        if (m_valid[idx] && m_tag[idx] == tg) begin
          if (ut) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          else    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
          if (ut) m_tgt[idx] = utg;
        end else if (ut) begin
          m_valid[idx] = 1'b1; m_tag[idx] = tg;
          m_tgt[idx] = utg; m_ctr[idx] = 2;
        end
        m_ghr = ((m_ghr << 1) | int'(ut)) & 15;
      end
      if (m_cnt < DEP) m_cnt++;
    end
    #1;
  endtask

  task automatic rnd_step(input logic r);
    logic [31:0] lpc, upc;
    lpc = pcf($urandom_range(0, 15), $urandom_range(0, 3), m_ghr);
    upc = pcf($urandom_range(0, 15), $urandom_range(0, 3), 0);
    step(r, ($urandom_range(0, 9) != 0), lpc,
         $urandom_range(0, 1), upc, $urandom & 32'hffff_fffc,
         $urandom_range(0, 2) != 0,
         ($urandom_range(0, 3) != 0) ? 4'(m_ghr) : 4'($urandom));
  endtask

  task automatic sweep_len(input string tag);
    int zeros = 0;
    for (int i = 0; i < 300; i++) begin
      rnd_step(1'b0);
      if (s_ready) break;
      zeros++;
    end
    chk(tag, 32'(zeros), 32'(DEP));
  endtask

  task automatic sat(input logic t, input logic exp_tk, input string tag);
    step(0, 0, 0, 1, pcf(32, 5, 0), 32'h4000, t, 0);
    step(0, 1, pcf(32, 5, m_ghr), 0, 0, 0, 0, 0);
    chk({tag, "_hit"}, 32'(s_hit), 1);
    chk(tag, 32'(s_taken), 32'(exp_tk));
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rnd_step(1'b1);
    chk("rst_tgt", s_tgt, i_lookup_pc + 4);
    for (int i = 0; i < 100; i++) rnd_step(1'b0);
    rnd_step(1'b1);
    sweep_len("sweep_restart");

    step(0, 0, 0, 1, pcf(80, 1, 0), 32'h200, 1, 0);
    step(0, 1, pcf(80, 1, m_ghr), 0, 0, 0, 0, 0);
    chk("alloc_hit", 32'(s_hit), 1);
    chk("alloc_tgt", s_tgt, 32'h200);
    step(0, 1, pcf(80, 2, m_ghr), 0, 0, 0, 0, 0);
    chk("conflict_hit", 32'(s_hit), 0);
    chk("conflict_tgt", s_tgt, pcf(80, 2, m_ghr) + 4);

    step(0, 0, 0, 1, pcf(32, 5, 0), 32'h4000, 1, 0);
    for (int i = 0; i < 3; i++) sat(1, 1, "sat_up");
    sat(0, 1, "sat_dn2");
    sat(0, 0, "sat_dn1");
    chk("sat_nt_tgt", s_tgt, pcf(32, 5, m_ghr) + 4);
    for (int i = 0; i < 6; i++) sat(0, 0, "sat_floor");
    sat(1, 0, "sat_from0");
    sat(1, 1, "sat_to2");

    step(0, 0, 0, 1, pcf(48, 7, 0), 32'h700, 0, 0);
    step(0, 1, pcf(48, 7, m_ghr), 0, 0, 0, 0, 0);
    chk("nt_miss", 32'(s_hit), 0);
    chk("nt_ghr0", 32'(s_ghr[0]), 0);

    step(0, 1, pcf(64, 9, m_ghr), 1, pcf(64, 9, m_ghr), 32'h900, 1,
         4'(m_ghr));
    chk("coll_same", 32'(s_hit), 0);
    step(0, 1, pcf(64, 9, m_ghr), 0, 0, 0, 0, 0);
    chk("coll_next", 32'(s_hit), 1);

    step(0, 0, 0, 1, pcf(1, 64, 0), 32'h10, 1, 0);
    step(0, 0, 0, 1, pcf(2, 64, 0), 32'h20, 1, 0);
    step(0, 0, 0, 1, pcf(3, 64, 0), 32'h30, 0, 0);
    step(0, 0, 0, 1, pcf(4, 64, 0), 32'h40, 1, 0);
    step(0, 1, 32'h40, 0, 0, 0, 0, 0);
    chk("gshare_ghr", 32'(s_ghr), 32'hd);
    step(0, 0, 0, 1, 32'h40, 32'h998, 1, 4'hd);
    step(0, 1, 32'h58, 0, 0, 0, 0, 0);
    chk("gshare_hit", 32'(s_hit), 1);
    chk("gshare_tgt", s_tgt, 32'h998);

    for (int i = 0; i < 700; i++) rnd_step(1'b0);
    rnd_step(1'b1);
    sweep_len("sweep_ready_rst");
    for (int i = 0; i < 200; i++) rnd_step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
